// File: rtl/d_ff.sv
// Bank of WIDTH independent positive-edge D flip-flops with async
// active-low preset (p) and reset (r); reset dominates preset.
// Ports: q/qbar state and complement, d data, c clock, p preset_n, r reset_n.
// Build option: define D_FF_GATE_LEVEL_EN for the six-NAND structural model.
`timescale 1ns/1ps
module d_ff #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    input  logic [WIDTH-1:0] d,
    input  logic             c,
    input  logic             p,
    input  logic             r
);

`ifdef D_FF_GATE_LEVEL_EN

    // Effective preset pe = p | ~r, so an asserted reset masks preset.
    wire p_inv;
    wire r_inv;
    wire pe;

    nand #0.2 u_pinv (p_inv, p, p);
    nand #0.2 u_rinv (r_inv, r, r);
    nand #0.2 u_pe   (pe, p_inv, r);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire n1;
        wire n2;
        wire n3;
        wire n4;
        wire qo;
        wire qbo;

        nand #0.2 u_g1 (n1, pe, n4, n2);
        nand #0.2 u_g2 (n2, n1, r, c);
        nand #0.2 u_g3 (n3, n2, c, n4);
        nand #0.2 u_g4 (n4, n3, r, d[i]);
        nand #0.2 u_q  (qo, pe, n2, qbo);
        nand #0.2 u_qb (qbo, qo, r, n3);

        assign q[i]    = qo;
        assign qbar[i] = qbo;
    end

`else

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = d;
    end

    always_ff @(posedge c or negedge r or negedge p) begin
        if (!r) begin
            state_q <= '0;
        end else if (!p) begin
            state_q <= '1;
        end else begin
            state_q <= state_d;
        end
    end

    assign q    = state_q;
    assign qbar = ~state_q;

`endif

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: directed plan followed by random ops
// compared against a rule-level reference model (1-bit and 4-bit banks).
`timescale 1ns/1ps
module tb_d_ff;

    logic       c;
    logic       p;
    logic       r;
    logic       d1;
    logic [3:0] d4;
    logic       q1;
    logic       qb1;
    logic [3:0] q4;
    logic [3:0] qb4;

    int errs   = 0;
    int checks = 0;

    logic       exp1;
    logic [3:0] exp4;

    d_ff #(.WIDTH(1)) u_dff1 (
        .q    (q1),
        .qbar (qb1),
        .d    (d1),
        .c    (c),
        .p    (p),
        .r    (r)
    );

    d_ff #(.WIDTH(4)) u_dff4 (
        .q    (q4),
        .qbar (qb4),
        .d    (d4),
        .c    (c),
        .p    (p),
        .r    (r)
    );

    task automatic chk(input string tag);
        checks++;
        assert (q1 === exp1 && qb1 === ~exp1)
        else begin
            errs++;
            $error("FAIL %s w1: q=%b qbar=%b want q=%b qbar=%b",
                   tag, q1, qb1, exp1, ~exp1);
        end
        checks++;
        assert (q4 === exp4 && qb4 === ~exp4)
        else begin
            errs++;
            $error("FAIL %s w4: q=%h qbar=%h want q=%h qbar=%h",
                   tag, q4, qb4, exp4, ~exp4);
        end
    endtask

    task automatic rise();
        c = 1'b1;
        #5;
        if (p && r) begin
            exp1 = d1;
            exp4 = d4;
        end
    endtask

    task automatic fall();
        c = 1'b0;
        #5;
    endtask

    task automatic setd(input logic [3:0] v4, input logic v1);
        d4 = v4;
        d1 = v1;
        #5;
    endtask

    initial begin
        c  = 1'b0;
        p  = 1'b1;
        r  = 1'b1;
        d1 = 1'b0;
        d4 = 4'h0;
        #5;

        // reset state
        r = 1'b0;
        #5;
        exp1 = 1'b0;
        exp4 = 4'h0;
        chk("reset");
        r = 1'b1;
        #5;
        chk("reset_rel");

        // preset overrides data and clock
        p = 1'b0;
        #5;
        exp1 = 1'b1;
        exp4 = 4'hF;
        chk("preset");
        rise();
        chk("preset_d0_clk");
        fall();
        setd(4'hF, 1'b1);
        rise();
        chk("preset_d1_clk");
        fall();
        p = 1'b1;
        #5;
        chk("preset_rel");

        // reset overrides clock
        setd(4'h0, 1'b0);
        r = 1'b0;
        #5;
        exp1 = 1'b0;
        exp4 = 4'h0;
        rise();
        chk("reset_d0_clk");
        fall();
        setd(4'hF, 1'b1);
        rise();
        chk("reset_d1_clk");
        fall();
        r = 1'b1;
        #5;
        chk("reset_rel_hold");

        // normal capture
        rise();
        exp1 = 1'b1;
        exp4 = 4'hF;
        chk("cap_1");
        setd(4'h0, 1'b0);
        chk("d_change_no_edge");
        fall();
        chk("fall_edge");
        rise();
        exp1 = 1'b0;
        exp4 = 4'h0;
        chk("cap_0");
        fall();

        // conflict and release
        setd(4'h5, 1'b1);
        rise();
        fall();
        p = 1'b0;
        r = 1'b0;
        #5;
        exp1 = 1'b0;
        exp4 = 4'h0;
        chk("conflict");
        setd(4'hA, 1'b1);
        p = 1'b1;
        r = 1'b1;
        #5;
        chk("release_hold");
        rise();
        exp1 = 1'b1;
        exp4 = 4'hA;
        chk("release_cap");
        fall();

        // random operations against the rule model
        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1: begin
                    setd(4'($urandom), 1'($urandom));
                    rise();
                    chk("rnd_cap");
                    fall();
                end
                2: begin
                    r = 1'b0;
                    #5;
                    exp1 = 1'b0;
                    exp4 = 4'h0;
                    rise();
                    fall();
                    r = 1'b1;
                    #5;
                    chk("rnd_reset");
                end
                3: begin
                    p = 1'b0;
                    #5;
                    exp1 = 1'b1;
                    exp4 = 4'hF;
                    rise();
                    fall();
                    p = 1'b1;
                    #5;
                    chk("rnd_preset");
                end
                4: begin
                    setd(4'($urandom), 1'($urandom));
                    chk("rnd_d_only");
                end
                default: begin
                    p = 1'b0;
                    r = 1'b0;
                    #5;
                    exp1 = 1'b0;
                    exp4 = 4'h0;
                    chk("rnd_conflict");
                    p = 1'b1;
                    r = 1'b1;
                    #5;
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/d_ff.md
# d_ff

Single-bit positive-edge D flip-flop with asynchronous active-low preset and asynchronous active-low reset, plus complementary outputs. It is the basic state element of the gate-level datapath: registers, counters and pipeline latches are built from instances of it. A `WIDTH` parameter allows a bank of identical, independent bits to share one clock, preset and reset.

## Interface
Parameters:
- `WIDTH`, default 1: number of independent flip-flop bits.

Ports, in positional order:
- `q`, output, `WIDTH` bits: stored state.
- `qbar`, output, `WIDTH` bits: complement of `q`, always `~q` outside X states.
- `d`, input, `WIDTH` bits: data sampled on the rising edge of `c`.
- `c`, input, 1 bit: clock. The design has one clock; all capture happens on its rising edge.
- `p`, input, 1 bit: preset, asynchronous, active-low. Forces `q` to all ones.
- `r`, input, 1 bit: reset, asynchronous, active-low. Forces `q` to all zeros.

Clock is `c` and reset is `r`. Reset is asynchronous and active-low.

## Operation
- Rising edge of `c` with `p=1` and `r=1`: `q <= d` and `qbar <= ~d` on every bit.
- `r=0`: `q=0` and `qbar=all ones`, immediately and independent of `c` and `d`. This holds for as long as `r` stays low.
- `p=0` with `r=1`: `q=all ones` and `qbar=0`, immediately and independent of `c` and `d`.
- `p=0` and `r=0` together: reset dominates, so `q=0` and `qbar=all ones`. The outputs must never both be 1.
- Clock edges during an asserted preset or reset are ignored, and no capture is queued.
- Releasing `p` or `r`: `q` holds its forced value until the next rising edge of `c`, which captures `d` normally.
- Falling edges of `c` and changes on `d` between rising edges do not change `q`.
- Reset value: `q=0`, `qbar=all ones`.
- Power-up without preset or reset: `q` is X until the first reset, preset or rising clock edge.

## Timing
- Capture latency is zero cycles. `q` reflects `d` after the rising edge, once the propagation delay has elapsed.
- Asynchronous path: `q` and `qbar` respond to the falling edge of `p` or `r` without any clock.
- Propagation delay from any input change to settled outputs must be at most 2 ns. Checkers sample 5 ns after stimulus.
- Bits are fully independent; there is no cross-bit interaction.
- Setup and hold: `d` must be stable 1 ns before and 1 ns after the rising edge of `c`. Violations give an undefined `q` in that bit only.

## Configuration
- Macro `D_FF_GATE_LEVEL_EN`.
  - Defined: each bit is built structurally from primitive NAND gates in the classic six-NAND edge-triggered (7474-style) topology. Preset and reset feed the appropriate gates.
  - Defined: preset is internally gated with reset (effective preset = `p | ~r`) so that reset dominates.
  - Defined: each primitive carries a 0.2 ns delay.
  - Undefined: the block is a behavioral model, an always block on `posedge c`, `negedge r` and `negedge p`, with reset checked first and zero delay.
  - Both builds must produce identical `q` and `qbar` at every sample point of the test plan.

## Test plan
- `d=0`, `p=0`, `r=1`, clock 0→1, sample 5 ns later → `q=1`, `qbar=0` (preset overrides data).
- `d=1`, `p=0`, `r=1`, clock 0→1 → `q=1`, `qbar=0`.
- `d=0`, `p=1`, `r=0`, clock 0→1 → `q=0`, `qbar=1` (reset overrides clock).
- `d=1`, `p=1`, `r=0`, clock 0→1 → `q=0`, `qbar=1`.
- Normal capture:
  - `p=1`, `r=1`, `d=1`, rising edge → `q=1`.
  - Then change `d=0` with no edge → `q` stays 1.
  - Falling edge → `q` stays 1.
  - Next rising edge → `q=0`.
- Conflict and release:
  - `p=0` and `r=0` with no clock → `q=0`, `qbar=1`.
  - Release both with `d=1` → `q` stays 0 until the next rising edge, then `q=1`.
  - Repeat with `WIDTH=4` and `d=4'hA` → `q=4'hA`.
